// File: rtl/mpmc9_pkg.sv
// Shared types and constants for the mpmc9 strip sequencer.
package mpmc9_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_WR_DATA = 3'd1,
    SEQ_WR_CMD  = 3'd2,
    SEQ_RD_CMD  = 3'd3,
    SEQ_RD_WAIT = 3'd4,
    SEQ_DONE    = 3'd5
  } seq_state_t;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  localparam int unsigned       WDOG_W     = 12;
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = 12'hFFF;

endpackage

// File: rtl/mpmc9_rd_return_cnt.sv
// Counts returning MIG read beats; flags when the beat for strip 'last' has arrived.
module mpmc9_rd_return_cnt #(
  parameter int unsigned STRIP_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic               beat,
  input  logic [STRIP_W-1:0] last,
  output logic               rd_valid,
  output logic [STRIP_W-1:0] rd_strip,
  output logic               all_returned,
  output logic               last_beat_c
);

  logic [STRIP_W-1:0] cnt;
  logic               take_c;

  assign take_c      = en && beat && !all_returned;
  assign last_beat_c = take_c && (cnt == last);

  // Count saturates at last so it never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      rd_valid     <= 1'b0;
      rd_strip     <= '0;
      all_returned <= 1'b0;
    end else begin
      rd_valid <= take_c;
      if (clr) begin
        cnt          <= '0;
        rd_strip     <= '0;
        all_returned <= 1'b0;
      end else if (take_c) begin
        rd_strip <= cnt;
        if (cnt == last) all_returned <= 1'b1;
        else             cnt          <= cnt + STRIP_W'(1);
      end
    end
  end

endmodule

// File: rtl/mpmc9_strip_seq.sv
// Sequences one multi-strip read/write burst onto the MIG app interface.
// Optional stall watchdog with err output: define MPMC9_SEQ_WATCHDOG_EN.
module mpmc9_strip_seq
  import mpmc9_pkg::*;
#(
  parameter int unsigned ADDR_W   = 29,
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned STRIP_W  = 6,
  parameter int unsigned ADDR_INC = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  calib_done,
  input  logic                  req,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_adr,
  input  logic [STRIP_W-1:0]    req_num_strips,
  output logic                  req_ack,
  output logic                  busy,
  output logic                  done,
`ifdef MPMC9_SEQ_WATCHDOG_EN
  output logic                  err,
`endif
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_mask,
  output logic [STRIP_W-1:0]    strip_cnt,
  output logic                  app_en,
  output logic [2:0]            app_cmd,
  output logic [ADDR_W-1:0]     app_addr,
  input  logic                  app_rdy,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  output logic [DATA_W-1:0]     app_wdf_data,
  output logic [DATA_W/8-1:0]   app_wdf_mask,
  input  logic                  app_wdf_rdy,
  input  logic                  app_rd_data_valid,
  output logic                  rd_valid,
  output logic [STRIP_W-1:0]    rd_strip
);

  seq_state_t         state, next_state;
  logic [STRIP_W-1:0] last;
  logic               accept_c, step_c, cmd_last_c, busy_st_c, wdog_fire_c;
  logic               en_d, wren_d, busy_d;
  logic               rd_en_c, all_returned, last_beat_c;

  assign cmd_last_c = (strip_cnt == last);
  assign busy_st_c  = state inside {SEQ_WR_DATA, SEQ_WR_CMD, SEQ_RD_CMD, SEQ_RD_WAIT};
  assign rd_en_c    = (state == SEQ_RD_CMD) || (state == SEQ_RD_WAIT);

  // Write data is indexed by strip_cnt and qualified by the registered wren.
  assign app_wdf_data = wr_data;
  assign app_wdf_mask = wr_mask;
  assign app_wdf_end  = app_wdf_wren;

  mpmc9_rd_return_cnt #(.STRIP_W(STRIP_W)) u_rd_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (accept_c),
    .en           (rd_en_c),
    .beat         (app_rd_data_valid),
    .last         (last),
    .rd_valid     (rd_valid),
    .rd_strip     (rd_strip),
    .all_returned (all_returned),
    .last_beat_c  (last_beat_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= SEQ_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      SEQ_IDLE:    if (req && calib_done) next_state = req_we ? SEQ_WR_DATA : SEQ_RD_CMD;
      SEQ_WR_DATA: if (app_wdf_rdy) next_state = SEQ_WR_CMD;
      SEQ_WR_CMD:  if (app_rdy) next_state = cmd_last_c ? SEQ_DONE : SEQ_WR_DATA;
      SEQ_RD_CMD:  if (app_rdy && cmd_last_c) next_state = SEQ_RD_WAIT;
      SEQ_RD_WAIT: if (all_returned || last_beat_c) next_state = SEQ_DONE;
      SEQ_DONE:    next_state = SEQ_IDLE;
      default:     next_state = SEQ_IDLE;
    endcase
    if (wdog_fire_c) next_state = SEQ_DONE;
  end

  // Output process: next values of the registered handshake outputs.
  always_comb begin
    accept_c = 1'b0;
    step_c   = 1'b0;
    case (state)
      SEQ_IDLE:               accept_c = req && calib_done;
      SEQ_WR_CMD, SEQ_RD_CMD: step_c   = app_rdy && !cmd_last_c && !wdog_fire_c;
      default: ;
    endcase
    en_d   = (next_state == SEQ_WR_CMD) || (next_state == SEQ_RD_CMD);
    wren_d = (next_state == SEQ_WR_DATA);
    busy_d = next_state inside {SEQ_WR_DATA, SEQ_WR_CMD, SEQ_RD_CMD, SEQ_RD_WAIT};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_ack      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      app_en       <= 1'b0;
      app_wdf_wren <= 1'b0;
      app_cmd      <= 3'b000;
      app_addr     <= '0;
      strip_cnt    <= '0;
      last         <= '0;
    end else begin
      req_ack      <= accept_c;
      busy         <= busy_d;
      done         <= (state == SEQ_DONE);
      app_en       <= en_d;
      app_wdf_wren <= wren_d;
      if (accept_c) begin
        app_addr  <= req_adr;
        last      <= req_num_strips;
        app_cmd   <= req_we ? CMD_WRITE : CMD_READ;
        strip_cnt <= '0;
      end else if (step_c) begin
        app_addr  <= app_addr + ADDR_W'(ADDR_INC);
        strip_cnt <= strip_cnt + STRIP_W'(1);
      end
    end
  end

`ifdef MPMC9_SEQ_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_hit;

  assign wdog_fire_c = busy_st_c && (wdog_cnt == WDOG_LIMIT);

  // Any MIG handshake activity while busy restarts the stall window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
      wdog_hit <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (!busy_st_c || app_rdy || app_wdf_rdy || app_rd_data_valid) wdog_cnt <= '0;
      else if (!wdog_fire_c)                                         wdog_cnt <= wdog_cnt + WDOG_W'(1);
      if (accept_c)         wdog_hit <= 1'b0;
      else if (wdog_fire_c) wdog_hit <= 1'b1;
      err <= (state == SEQ_DONE) && wdog_hit;
    end
  end
`else
  assign wdog_fire_c = 1'b0;
`endif

endmodule

// File: tb/tb_mpmc9_strip_seq.sv
// Directed scoreboard bench for mpmc9_strip_seq with a small MIG response model.
module tb_mpmc9_strip_seq;
  import mpmc9_pkg::*;

  localparam int RD_LAT = 5;

  logic         clk = 1'b0;
  logic         rst_n, calib_done, req, req_we;
  logic [28:0]  req_adr;
  logic [5:0]   req_num_strips;
  logic         req_ack, busy, done;
  logic [127:0] wr_data;
  logic [15:0]  wr_mask;
  logic [5:0]   strip_cnt;
  logic         app_en;
  logic [2:0]   app_cmd;
  logic [28:0]  app_addr;
  logic         app_rdy, app_wdf_wren, app_wdf_end;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_rdy, app_rd_data_valid, rd_valid;
  logic [5:0]   rd_strip;

  mpmc9_strip_seq dut (
    .clk(clk), .rst_n(rst_n), .calib_done(calib_done), .req(req), .req_we(req_we),
    .req_adr(req_adr), .req_num_strips(req_num_strips), .req_ack(req_ack), .busy(busy),
    .done(done), .wr_data(wr_data), .wr_mask(wr_mask), .strip_cnt(strip_cnt),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data_valid(app_rd_data_valid), .rd_valid(rd_valid), .rd_strip(rd_strip)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  int busy_cnt, done_cnt, en_cnt, ack_cnt, acc_cnt, rdv_cnt;
  int ack_cyc, done_cyc, rdv_cyc, calib_cyc;
  int stall_left = 0, wdf_stall_left = 0;
  logic [5:0]   stall_strip = '0;
  logic [31:0]  wr_seed = 32'h1234_0000;
  logic [31:0]  cmd_q[$];
  logic [143:0] wdf_q[$];
  logic [5:0]   rd_q[$];
  int           beat_due[$];

  function automatic logic [127:0] wpat(input logic [31:0] seed, input logic [5:0] i);
    logic [31:0] w;
    w = seed ^ {26'd0, i};
    return {w, ~w, w + 32'd1, w ^ 32'hFFFF_0000};
  endfunction

  function automatic logic [15:0] mpat(input logic [5:0] i);
    return ~(16'd1 << i[3:0]);
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe/score at negedge, then drive the MIG model after the edge.
  task automatic tick();
    logic [31:0]  e;
    logic [143:0] w;
    logic [5:0]   r;
    @(negedge clk);
    if (busy)    busy_cnt++;
    if (app_en)  en_cnt++;
    if (req_ack) begin ack_cnt++; ack_cyc = cyc; end
    if (done)    begin done_cnt++; done_cyc = cyc; end
    if (app_en && app_rdy) begin
      acc_cnt++;
      chk("cmd_expected", 160'(cmd_q.size() != 0), 160'(1));
      if (cmd_q.size() != 0) begin
        e = cmd_q.pop_front();
        chk("cmd", 160'({app_cmd, app_addr}), 160'(e));
        if (e[31:29] == CMD_READ) beat_due.push_back(cyc + RD_LAT);
      end
    end else if (app_en && cmd_q.size() != 0) begin
      e = cmd_q[0];
      chk("stall_addr", 160'(app_addr), 160'(e[28:0]));
    end
    if (app_wdf_wren) chk("wdf_end", 160'(app_wdf_end), 160'(1));
    if (app_wdf_wren && app_wdf_rdy) begin
      chk("wdf_expected", 160'(wdf_q.size() != 0), 160'(1));
      if (wdf_q.size() != 0) begin
        w = wdf_q.pop_front();
        chk("wdf", 160'({app_wdf_data, app_wdf_mask}), 160'(w));
      end
    end
    if (rd_valid) begin
      rdv_cnt++;
      rdv_cyc = cyc;
      chk("rd_expected", 160'(rd_q.size() != 0), 160'(1));
      if (rd_q.size() != 0) begin
        r = rd_q.pop_front();
        chk("rd_strip", 160'(rd_strip), 160'(r));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    app_rd_data_valid = 1'b0;
    if (beat_due.size() != 0 && beat_due[0] == cyc) begin
      app_rd_data_valid = 1'b1;
      void'(beat_due.pop_front());
    end
    app_rdy = 1'b1;
    if (app_en && stall_left > 0 && strip_cnt == stall_strip) begin
      app_rdy = 1'b0;
      stall_left--;
    end
    app_wdf_rdy = 1'b1;
    if (app_wdf_wren && wdf_stall_left > 0) begin
      app_wdf_rdy = 1'b0;
      wdf_stall_left--;
    end
    wr_data = wpat(wr_seed, strip_cnt);
    wr_mask = mpat(strip_cnt);
  endtask

  task automatic expect_burst(input logic we, input logic [28:0] adr, input logic [5:0] num);
    for (int i = 0; i <= int'(num); i++) begin
      cmd_q.push_back({we ? CMD_WRITE : CMD_READ, 29'(adr + 29'(8 * i))});
      if (we) wdf_q.push_back({wpat(wr_seed, 6'(i)), mpat(6'(i))});
      else    rd_q.push_back(6'(i));
    end
    busy_cnt = 0; done_cnt = 0; en_cnt = 0; ack_cnt = 0; acc_cnt = 0; rdv_cnt = 0;
    req = 1'b1; req_we = we; req_adr = adr; req_num_strips = num;
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    while (ack_cnt == 0 && n < 50) begin tick(); n++; end
    req = 1'b0;
    chk({tag, "_ack"}, 160'(ack_cnt), 160'(1));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 400) begin tick(); n++; end
    tick();
    tick();
    chk({tag, "_done_pulses"}, 160'(done_cnt), 160'(1));
    chk({tag, "_queues_drained"}, 160'(cmd_q.size() + wdf_q.size() + rd_q.size()), 160'(0));
    chk({tag, "_idle_busy"}, 160'(busy), 160'(0));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_ack"}, 160'(req_ack), 160'(0));
    chk({tag, "_busy"}, 160'(busy), 160'(0));
    chk({tag, "_done"}, 160'(done), 160'(0));
    chk({tag, "_app_en"}, 160'(app_en), 160'(0));
    chk({tag, "_wdf_wren"}, 160'(app_wdf_wren), 160'(0));
    chk({tag, "_rd_valid"}, 160'(rd_valid), 160'(0));
    chk({tag, "_strip_cnt"}, 160'(strip_cnt), 160'(0));
    chk({tag, "_rd_strip"}, 160'(rd_strip), 160'(0));
    chk({tag, "_app_addr"}, 160'(app_addr), 160'(0));
    chk({tag, "_app_cmd"}, 160'(app_cmd), 160'(0));
  endtask

  initial begin
    rst_n = 1'b0; calib_done = 1'b1; req = 1'b0; req_we = 1'b0;
    req_adr = '0; req_num_strips = '0; wr_data = '0; wr_mask = '0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0;
    repeat (2) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // Four-strip write with a ready MIG.
    wr_seed = 32'hA5A5_0000;
    expect_burst(1'b1, 29'h100, 6'd3);
    wait_ack("wr4");
    wait_done("wr4");
    chk("wr4_busy_cycles", 160'(busy_cnt), 160'(8));
    chk("wr4_en_cycles", 160'(en_cnt), 160'(4));

    // Single-strip read, data five cycles after the command.
    expect_burst(1'b0, 29'h0400, 6'd0);
    wait_ack("rd1");
    wait_done("rd1");
    chk("rd1_en_cycles", 160'(en_cnt), 160'(1));
    chk("rd1_rd_valid_count", 160'(rdv_cnt), 160'(1));
    chk("rd1_done_after_rdv", 160'(done_cyc - rdv_cyc), 160'(1));

    // Three-strip read with a 3-cycle app_rdy stall on strip 1.
    stall_strip = 6'd1; stall_left = 3;
    expect_burst(1'b0, 29'h0800, 6'd2);
    wait_ack("rd3");
    wait_done("rd3");
    chk("rd3_en_cycles", 160'(en_cnt), 160'(6));
    chk("rd3_stall_consumed", 160'(stall_left), 160'(0));

    // Address wrap with a 2-cycle write-data stall.
    wr_seed = 32'h0F0F_1000;
    wdf_stall_left = 2;
    expect_burst(1'b1, 29'h1FFF_FFF8, 6'd1);
    wait_ack("wrap");
    wait_done("wrap");
    chk("wrap_busy_cycles", 160'(busy_cnt), 160'(6));

    // Full 64-strip read, commands back to back.
    expect_burst(1'b0, 29'h8000, 6'd63);
    wait_ack("rd64");
    wait_done("rd64");
    chk("rd64_en_cycles", 160'(en_cnt), 160'(64));
    chk("rd64_rd_valid_count", 160'(rdv_cnt), 160'(64));

    // Request held while calibration is still pending.
    calib_done = 1'b0;
    wr_seed = 32'h7777_0000;
    expect_burst(1'b1, 29'h4000, 6'd0);
    repeat (4) tick();
    chk("calib_no_ack", 160'(ack_cnt), 160'(0));
    chk("calib_no_busy", 160'(busy_cnt), 160'(0));
    calib_done = 1'b1;
    calib_cyc = cyc;
    wait_ack("calib");
    chk("calib_ack_latency", 160'(ack_cyc - calib_cyc), 160'(1));
    wait_done("calib");

    // Reset mid-read with beats still outstanding.
    expect_burst(1'b0, 29'h2000, 6'd3);
    wait_ack("abort");
    begin
      int n = 0;
      while (acc_cnt < 2 && n < 50) begin tick(); n++; end
    end
    chk("abort_two_cmds", 160'(acc_cnt >= 2), 160'(1));
    rst_n = 1'b0;
    tick();
    check_zero("abort");
    rst_n = 1'b1;
    cmd_q.delete(); rd_q.delete(); wdf_q.delete();
    rdv_cnt = 0; busy_cnt = 0;
    repeat (12) tick();
    chk("abort_late_beats_ignored", 160'(rdv_cnt), 160'(0));
    chk("abort_stays_idle", 160'(busy_cnt), 160'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpmc9_strip_seq.md
Name: mpmc9_strip_seq

Overview:
- Sequences one multi-strip burst (read or write) onto the MIG user "app" interface for the mpmc9 controller.
- Sits between the port arbiter and the MIG. Accepts one granted request, then owns the burst until it completes:
  - issues app_en commands, retrying while app_rdy is low;
  - pushes write strips through the wdf channel;
  - counts strips out and read beats back.
- Replaces the ad-hoc state/strip_cnt bookkeeping that now lives in the controller top.

Parameters:
- ADDR_W, 29, MIG app_addr width.
- DATA_W, 128, app data width (one strip).
- STRIP_W, 6, strip counter width; a burst is 1..2^STRIP_W strips.
- ADDR_INC, 8, app_addr increment per strip.

Ports:
- clk  in  1  controller clock (MIG ui_clk)
- rst_n  in  1  synchronous active-low reset
- calib_done  in  1  MIG calibration complete
- req  in  1  burst request from arbiter, held until req_ack
- req_we  in  1  1=write burst, 0=read burst
- req_adr  in  ADDR_W  first strip address
- req_num_strips  in  STRIP_W  index of last strip (0 = one strip)
- req_ack  out  1  one-cycle pulse: request latched
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse: burst complete
- wr_data  in  DATA_W  current write strip, indexed by strip_cnt
- wr_mask  in  DATA_W/8  active-low byte mask for wr_data
- strip_cnt  out  STRIP_W  current strip index (command side)
- app_en  out  1  MIG command valid
- app_cmd  out  3  3'b000 write, 3'b001 read
- app_addr  out  ADDR_W  command address
- app_rdy  in  1  MIG command accept
- app_wdf_wren  out  1  write data valid
- app_wdf_end  out  1  equals app_wdf_wren (one beat per strip)
- app_wdf_data  out  DATA_W  write data
- app_wdf_mask  out  DATA_W/8  write mask
- app_wdf_rdy  in  1  MIG write data accept
- app_rd_data_valid  in  1  MIG read beat valid
- rd_valid  out  1  registered copy of app_rd_data_valid while in RD_CMD/RD_WAIT
- rd_strip  out  STRIP_W  index of the returning read strip

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE. All outputs are 0: req_ack, busy, done, app_en, app_wdf_wren, rd_valid, strip_cnt, rd_strip, app_addr, app_cmd.
- Reset mid-burst aborts the burst; read beats arriving after reset are ignored.
- States are IDLE, WR_DATA, WR_CMD, RD_CMD, RD_WAIT, DONE.
- IDLE:
  - If req && calib_done: latch req_adr into app_addr, req_num_strips into last, req_we into we. Pulse req_ack, clear strip_cnt and rd_strip.
  - Then go to WR_DATA if we, else RD_CMD. busy=1 from the next cycle.
  - If req while !calib_done: no ack, stay in IDLE.
- WR_DATA:
  - Hold app_wdf_wren=1 with wr_data/wr_mask until a cycle with app_wdf_rdy=1; then go to WR_CMD.
  - Data precedes its command, which MIG permits.
- WR_CMD:
  - app_en=1, app_cmd=write, held until a cycle with app_rdy=1.
  - On that edge: if strip_cnt==last go to DONE; else strip_cnt+1, app_addr+ADDR_INC, go to WR_DATA.
- RD_CMD:
  - app_en=1, app_cmd=read.
  - Each cycle with app_rdy=1: if strip_cnt==last go to RD_WAIT; else strip_cnt+1, app_addr+ADDR_INC.
  - Back-to-back commands are allowed: app_en is not dropped between accepted strips.
- Read return (counted in RD_CMD and RD_WAIT):
  - Each app_rd_data_valid: rd_valid=1 next cycle with rd_strip = returned count; the count then increments.
  - Leave RD_WAIT for DONE when a beat arrives while the count equals last.
- DONE: done=1 for one cycle, busy=0, return to IDLE. A new req is not acked in the DONE cycle.
- Arithmetic:
  - app_addr wraps modulo 2^ADDR_W.
  - strip_cnt never passes last, so there is no counter wrap.
  - last = 2^STRIP_W-1 gives a full 64-strip burst.
- Simultaneous events:
  - A read beat in the same cycle as the final command accept is counted.
  - If all beats have returned when RD_WAIT is entered, go to DONE next cycle.
- app_rdy or app_wdf_rdy stuck low: remain in state indefinitely, unless the watchdog feature below is compiled in.

Optional Feature:
- Macro: MPMC9_SEQ_WATCHDOG_EN.
- With it: a 12-bit counter clears on any app_rdy, app_wdf_rdy or app_rd_data_valid while busy, and increments otherwise. On reaching 4095: go to DONE, and assert output err (1 bit) together with done. err is 0 on reset.
- Without it: no counter and no err port; stalls are unbounded.

Decomposition:
- mpmc9_pkg gains:
  - typedef enum seq_state_t for the six states;
  - constants CMD_WRITE=3'b000 and CMD_READ=3'b001;
  - localparam WDOG_LIMIT.
- One natural sub-module, mpmc9_rd_return_cnt: counts app_rd_data_valid and produces rd_valid, rd_strip and an all_returned flag for the given last.

Test Plan:
- Write burst, adr=0x100, num_strips=3, app_rdy/app_wdf_rdy always 1 -> 4 wdf beats. Commands at 0x100, 0x108, 0x110, 0x118. One done pulse. 8 busy cycles.
- Read burst, num_strips=0, read data 5 cycles after command -> one app_en cycle. rd_valid with rd_strip=0. done the cycle after rd_valid.
- Read burst, num_strips=2, app_rdy low 3 cycles on strip 1 -> app_en held with app_addr constant across the stall. rd_strip sequence 0, 1, 2.
- req while calib_done=0, then calib_done=1 -> no req_ack until calib_done rises. Ack the cycle after it rises.
- rst_n low mid-read with 2 beats outstanding -> all outputs 0 next cycle. Late beats give no rd_valid.
- req_adr=2^29-8, num_strips=1 -> second command address 0 (wrap).
